hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage RISC-V core. It freezes the front end for handshaked data-memory accesses and inserts a bubble for load-use dependencies. It flushes wrong-path instructions after a taken branch and, optionally, detects memory handshake timeouts. It sits beside the ID/EX register and drives the write enables and flush controls of PC, IF/ID and ID/EX.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width (x0 = all-zero index).
- BRANCH_FLUSH_CYCLES, 1, cycles of IF/ID flush after a taken branch; legal 1..4.
- TIMEOUT_CYCLES, 256, maximum cycles spent in ACK_WAIT+BUSY before abort; legal 2..65535.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- IF_ID_rs1  in  REG_ADDR_W  rs1 of instruction in ID.
- IF_ID_rs2  in  REG_ADDR_W  rs2 of instruction in ID.
- ID_Ex_rd  in  REG_ADDR_W  rd of instruction in EX.
- ID_Ex_MemRead  in  1  EX instruction is a load.
- ID_Ex_MemWrite  in  1  EX instruction is a store.
- takeBranch  in  1  EX resolved a taken branch/jump.
- mem_ready  in  1  data memory idle/complete; low while an access is in progress.
- PC_write  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID register enable.
- ID_Ex_enable  out  1  ID/EX register enable.
- IF_ID_flush  out  1  load NOP into IF/ID.
- ID_Ex_flush  out  1  load NOP into ID/EX.
- mem_busy  out  1  memory FSM not in IDLE/DONE.
- mem_err  out  1  sticky timeout flag, cleared only by rst.

## Operation
- Memory FSM states: IDLE, ACK_WAIT, BUSY, DONE.
  - IDLE: if MemRead or MemWrite, go to ACK_WAIT.
  - ACK_WAIT: if mem_ready==0, go to BUSY.
  - BUSY: if mem_ready==1, go to DONE.
  - DONE: always go to IDLE. MemRead/MemWrite are ignored in DONE, because the access is still in ID/EX.
- mem_stall = (state==ACK_WAIT) | (state==BUSY) | (state==IDLE & (MemRead|MemWrite)).
- Load-use: lu_stall = (state==DONE) & ID_Ex_MemRead & (ID_Ex_rd!=0) & (ID_Ex_rd==IF_ID_rs1 | ID_Ex_rd==IF_ID_rs2).
- Flush counter fcnt (0..BRANCH_FLUSH_CYCLES-1):
  - Loaded with BRANCH_FLUSH_CYCLES-1 when takeBranch is accepted.
  - Decrements each non-stall cycle while nonzero.
  - Holds during mem_stall.
- Outputs, in priority order:
  - mem_stall: PC_write = IF_ID_write = ID_Ex_enable = 0; both flushes 0. takeBranch is ignored, since EX is frozen and re-asserts it later.
  - lu_stall: PC_write = IF_ID_write = 0; ID_Ex_enable = 1, ID_Ex_flush = 1; IF_ID_flush = 0. takeBranch is ignored (a load is never a branch).
  - takeBranch: all enables 1; IF_ID_flush = 1, ID_Ex_flush = 1.
  - fcnt != 0: all enables 1; IF_ID_flush = 1; ID_Ex_flush = 0.
  - otherwise: all enables 1; both flushes 0.
- mem_busy = (state==ACK_WAIT | state==BUSY).

## Timing
- Reset values (cycle after rst high):
  - state = IDLE, fcnt = 0, timeout counter = 0, mem_err = 0.
  - mem_busy = 0, flushes = 0.
  - Enables = 1 unless inputs present a memory op.
- rst asserted mid-access returns state to IDLE on the next edge. Outstanding memory completion is not tracked.
- Minimum memory stall: 3 cycles (IDLE-detect, ACK_WAIT, BUSY with mem_ready returning 0 then 1 immediately), then DONE releases with enables high.
- The stall decision in IDLE is combinational from MemRead/MemWrite (same cycle). All other decisions come from registered state.
- mem_ready high throughout ACK_WAIT holds the FSM in ACK_WAIT, still stalling.
- Simultaneous takeBranch and fcnt!=0: the branch wins and the counter is reloaded.
- rs==0 never triggers lu_stall. This holds even if rd==0 matches.

## Configuration
- HAZARD_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) runs in ACK_WAIT/BUSY and clears elsewhere.
  - On reaching TIMEOUT_CYCLES, the FSM goes to DONE and mem_err sets (sticky).
- Not defined:
  - No counter is present; the FSM waits indefinitely.
  - mem_err is tied to 0.

## Test plan
- Load rd=5, mem_ready drops 1 cycle later and rises 4 cycles later, ID rs1=3:
  - PC_write=0 for 6 cycles, then 1 in DONE.
  - No ID_Ex_flush.
  - mem_busy high exactly in ACK_WAIT/BUSY.
- Same load, ID rs2=5:
  - In DONE: PC_write=0, IF_ID_write=0, ID_Ex_flush=1, ID_Ex_enable=1.
  - Next cycle all enables 1.
- Load rd=0, rs1=0: no lu_stall in DONE.
- BRANCH_FLUSH_CYCLES=3, takeBranch pulse:
  - Cycle 0: IF_ID_flush=1 and ID_Ex_flush=1.
  - Cycles 1–2: IF_ID_flush only.
  - Cycle 3: none.
  - Repeat with a store starting on cycle 1: flush sequence pauses during stall and resumes after.
- HAZARD_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready stuck 0 after store:
  - FSM reaches DONE after 8 cycles in ACK_WAIT+BUSY.
  - mem_err=1 and stays 1 until rst.
- rst asserted in BUSY:
  - Next cycle state=IDLE, mem_busy=0, mem_err=0, fcnt=0.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: freezes PC/IF/ID/ID-EX during data-memory handshakes, bubbles load-use, flushes after taken branches.
// Stall decision in IDLE is combinational; all else from registered state. HAZARD_TIMEOUT_EN adds a handshake timeout with sticky mem_err.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W          = 5,
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter int TIMEOUT_CYCLES      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
    input  logic [REG_ADDR_W-1:0] ID_Ex_rd,
    input  logic                  ID_Ex_MemRead,
    input  logic                  ID_Ex_MemWrite,
    input  logic                  takeBranch,
    input  logic                  mem_ready,
    output logic                  PC_write,
    output logic                  IF_ID_write,
    output logic                  ID_Ex_enable,
    output logic                  IF_ID_flush,
    output logic                  ID_Ex_flush,
    output logic                  mem_busy,
    output logic                  mem_err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACK_WAIT = 2'd1,
        S_BUSY     = 2'd2,
        S_DONE     = 2'd3
    } mem_state_t;

    localparam int FW = (BRANCH_FLUSH_CYCLES > 1) ? $clog2(BRANCH_FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FC_LOAD = FW'(BRANCH_FLUSH_CYCLES - 1);

    mem_state_t    r_state;
    mem_state_t    w_state_nxt;
    logic [FW-1:0] r_fcnt;
    logic          w_mem_op;
    logic          w_in_wait;
    logic          w_mem_stall;
    logic          w_lu_stall;
    logic          w_timeout;
    logic          w_rd_hit;

    assign w_mem_op    = ID_Ex_MemRead | ID_Ex_MemWrite;
    assign w_in_wait   = (r_state == S_ACK_WAIT) || (r_state == S_BUSY);
    assign w_mem_stall = w_in_wait || ((r_state == S_IDLE) && w_mem_op);
    assign w_rd_hit    = (ID_Ex_rd == IF_ID_rs1) || (ID_Ex_rd == IF_ID_rs2);
    // rd != 0 also rules out a match on an x0 source operand
    assign w_lu_stall  = (r_state == S_DONE) && ID_Ex_MemRead &&
                         (ID_Ex_rd != '0) && w_rd_hit;
    assign mem_busy    = w_in_wait;

`ifdef HAZARD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] r_tcnt;
    logic          r_err;

    // Fires on the cycle that completes TIMEOUT_CYCLES cycles of waiting
    assign w_timeout = w_in_wait && ((r_tcnt + 1'b1) == TO_VAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_in_wait && !w_timeout) begin
                r_tcnt <= r_tcnt + 1'b1;
            end else begin
                r_tcnt <= '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_err = r_err;
`else
    // Without the timeout option the wait is unbounded; the parameter range makes this term constant 0.
    assign w_timeout = (TIMEOUT_CYCLES == 0) && w_in_wait;
    assign mem_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_mem_op) w_state_nxt = S_ACK_WAIT;
            S_ACK_WAIT: if (w_timeout) w_state_nxt = S_DONE;
                        else if (!mem_ready) w_state_nxt = S_BUSY;
            S_BUSY:     if (w_timeout || mem_ready) w_state_nxt = S_DONE;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Any stall freezes the flush sequence; a branch is only accepted when nothing stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt <= '0;
        end else if (!w_mem_stall && !w_lu_stall) begin
            if (takeBranch) begin
                r_fcnt <= FC_LOAD;
            end else if (r_fcnt != '0) begin
                r_fcnt <= r_fcnt - 1'b1;
            end
        end
    end

    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_Ex_enable = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_Ex_flush  = 1'b0;
        if (w_mem_stall) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_Ex_enable = 1'b0;
        end else if (w_lu_stall) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_Ex_flush  = 1'b1;
        end else if (takeBranch) begin
            IF_ID_flush  = 1'b1;
            ID_Ex_flush  = 1'b1;
        end else if (r_fcnt != '0) begin
            IF_ID_flush  = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench: each stimulus cycle queues the expected output vector, a negedge monitor pops and compares.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       mrd, mwr, tkb, mrdy;
    logic       pc_w, ifid_w, idex_en, ifid_fl, idex_fl, busy, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic [6:0] v;
    } exp_t;
    exp_t sb_q[$];

    // {PC_write, IF_ID_write, ID_Ex_enable, IF_ID_flush, ID_Ex_flush, mem_busy, mem_err}
    localparam logic [6:0] RUN   = 7'b1110000;
    localparam logic [6:0] MSTL  = 7'b0000000;
    localparam logic [6:0] MBSY  = 7'b0000010;
    localparam logic [6:0] LU    = 7'b0010100;
    localparam logic [6:0] BR    = 7'b1111100;
    localparam logic [6:0] FL    = 7'b1111000;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_ADDR_W(5),
        .BRANCH_FLUSH_CYCLES(3),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .IF_ID_rs1(rs1),
        .IF_ID_rs2(rs2),
        .ID_Ex_rd(rd),
        .ID_Ex_MemRead(mrd),
        .ID_Ex_MemWrite(mwr),
        .takeBranch(tkb),
        .mem_ready(mrdy),
        .PC_write(pc_w),
        .IF_ID_write(ifid_w),
        .ID_Ex_enable(idex_en),
        .IF_ID_flush(ifid_fl),
        .ID_Ex_flush(idex_fl),
        .mem_busy(busy),
        .mem_err(err)
    );

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t       e;
            logic [6:0] act;
            e   = sb_q.pop_front();
            act = {pc_w, ifid_w, idex_en, ifid_fl, idex_fl, busy, err};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
            end
        end
    end

    task automatic cyc(input string nm, input logic [6:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        mrd = 1'b0; mwr = 1'b0; tkb = 1'b0; mrdy = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        cyc("reset_idle", RUN);

        // Load rd=5, independent consumer rs1=3
        rd = 5'd5; rs1 = 5'd3; rs2 = 5'd7; mrd = 1'b1;
        cyc("ld_idle_stall", MSTL);
        mrdy = 1'b0;
        cyc("ld_ackwait", MBSY);
        cyc("ld_busy0", MBSY);
        cyc("ld_busy1", MBSY);
        cyc("ld_busy2", MBSY);
        mrdy = 1'b1;
        cyc("ld_busy_rdy", MBSY);
        cyc("ld_done_nohaz", RUN);
        mrd = 1'b0;
        cyc("ld_after", RUN);

        // Same load, dependent rs2=5; a branch during the bubble is ignored
        rs2 = 5'd5; mrd = 1'b1;
        cyc("lu_idle_stall", MSTL);
        mrdy = 1'b0;
        cyc("lu_ackwait", MBSY);
        cyc("lu_busy0", MBSY);
        cyc("lu_busy1", MBSY);
        cyc("lu_busy2", MBSY);
        mrdy = 1'b1;
        cyc("lu_busy_rdy", MBSY);
        tkb = 1'b1;
        cyc("lu_done_bubble", LU);
        tkb = 1'b0; mrd = 1'b0;
        cyc("lu_release", RUN);

        // rd=0 / rs1=0, mem_ready held high holds ACK_WAIT
        idle_inputs();
        mrd = 1'b1;
        cyc("x0_idle_stall", MSTL);
        cyc("x0_ackwait_hold", MBSY);
        mrdy = 1'b0;
        cyc("x0_ackwait", MBSY);
        mrdy = 1'b1;
        cyc("x0_busy", MBSY);
        cyc("x0_done_nolu", RUN);
        mrd = 1'b0;
        cyc("x0_after", RUN);

        // Branch flush sequence
        tkb = 1'b1;
        cyc("br_c0", BR);
        tkb = 1'b0;
        cyc("br_c1", FL);
        cyc("br_c2", FL);
        cyc("br_c3", RUN);

        // Branch followed by a store: sequence pauses and resumes
        tkb = 1'b1;
        cyc("brst_c0", BR);
        tkb = 1'b0; mwr = 1'b1;
        cyc("brst_idle_stall", MSTL);
        mrdy = 1'b0;
        cyc("brst_ackwait", MBSY);
        mrdy = 1'b1;
        cyc("brst_busy", MBSY);
        cyc("brst_done_fl", FL);
        mwr = 1'b0;
        cyc("brst_fl2", FL);
        cyc("brst_end", RUN);

        // Back-to-back branches reload the counter
        tkb = 1'b1;
        cyc("bb_c0", BR);
        cyc("bb_c1", BR);
        tkb = 1'b0;
        cyc("bb_c2", FL);
        cyc("bb_c3", FL);
        cyc("bb_c4", RUN);

        // Branch during a memory stall is dropped
        mrd = 1'b1; rd = 5'd5; tkb = 1'b1;
        cyc("brms_idle", MSTL);
        tkb = 1'b0; mrdy = 1'b0;
        cyc("brms_ackwait", MBSY);
        mrdy = 1'b1;
        cyc("brms_busy", MBSY);
        cyc("brms_done", RUN);
        mrd = 1'b0;
        cyc("brms_after", RUN);

        // Reset during BUSY with a pending flush count
        idle_inputs();
        tkb = 1'b1;
        cyc("rb_branch", BR);
        tkb = 1'b0; mwr = 1'b1;
        cyc("rb_idle_stall", MSTL);
        mrdy = 1'b0;
        cyc("rb_ackwait", MBSY);
        rst = 1'b1; mwr = 1'b0;
        cyc("rb_busy_rst", MBSY);
        rst = 1'b0;
        cyc("rb_after_rst", RUN);

        // Memory never answers
        mwr = 1'b1; mrdy = 1'b0;
        cyc("to_idle_stall", MSTL);
        for (int i = 0; i < 8; i++) begin
            cyc($sformatf("to_wait%0d", i), MBSY);
        end
`ifdef HAZARD_TIMEOUT_EN
        cyc("to_done_err", 7'b1110001);
        mwr = 1'b0;
        cyc("to_err_sticky", 7'b1110001);
        cyc("to_err_sticky2", 7'b1110001);
        do_reset();
        cyc("to_err_cleared", RUN);
`else
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("to_hang%0d", i), MBSY);
        end
        do_reset();
        cyc("to_reset_idle", RUN);
`endif

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
